// File: rtl/rx_frontend_os.sv
// Oversampling UART receive frontend: synchronises the line, majority-votes each bit,
// rejects start glitches and reports parity/framing/break status with one valid pulse per frame.
module rx_frontend_os #(
    parameter int DATA_MAX    = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [15:0]         cr_clk_div_i,
    input  logic [3:0]          cr_ds_i,
    input  logic [1:0]          cr_p_i,
    input  logic                cr_s_i,
    input  logic                uart_rx_i,
    output logic [DATA_MAX-1:0] data_o,
    output logic                parity_err_o,
    output logic                frame_err_o,
    output logic                break_o,
    output logic                output_valid_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] T_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] T_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] T_S2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t              state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                rx_s;
    logic                rx_q;
    logic                fall;
    logic [15:0]         div_cnt;
    logic [CW-1:0]       tick_cnt;
    logic                tick;
    logic                decide;
    logic                s0_q;
    logic                s1_q;
    logic                vote;
    logic [DATA_MAX-1:0] data_sr;
    logic [3:0]          bit_cnt;
    logic [3:0]          n_lat;
    logic [1:0]          p_lat;
    logic                s_lat;
    logic                stop_cnt;
    logic                par_q;
    logic                perr_q;
    logic                ferr_q;
    logic                zero_q;
    logic [4:0]          ds_plus1;
    logic [3:0]          n_next;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    assign fall   = rx_q & ~rx_s;
    assign tick   = (div_cnt == cr_clk_div_i);
    assign decide = tick && (tick_cnt == T_S2);
    // The third sample is the live line value, so the vote resolves on that same tick.
    assign vote   = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

    assign ds_plus1 = {1'b0, cr_ds_i} + 5'd1;
    assign n_next   = (ds_plus1 < 5'd5)             ? 4'd5 :
                      (ds_plus1 > 5'(DATA_MAX))     ? 4'(DATA_MAX) : ds_plus1[3:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
        end
    end

    // NOTE: every register below is updated with <= so all branches see pre-edge values;
    // later assignments in the same cycle (e.g. div_cnt in IDLE) simply take priority.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            rx_q           <= 1'b1;
            div_cnt        <= '0;
            tick_cnt       <= '0;
            s0_q           <= 1'b1;
            s1_q           <= 1'b1;
            data_sr        <= '0;
            bit_cnt        <= '0;
            n_lat          <= 4'd8;
            p_lat          <= 2'b00;
            s_lat          <= 1'b0;
            stop_cnt       <= 1'b0;
            par_q          <= 1'b0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            zero_q         <= 1'b0;
            data_o         <= '0;
            parity_err_o   <= 1'b0;
            frame_err_o    <= 1'b0;
            break_o        <= 1'b0;
            output_valid_o <= 1'b0;
        end else begin
            output_valid_o <= 1'b0;
            rx_q           <= rx_s;
            div_cnt        <= tick ? '0 : div_cnt + 16'd1;
            if (tick) begin
                tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + CW'(1);
                if (tick_cnt == T_S0) s0_q <= rx_s;
                if (tick_cnt == T_S1) s1_q <= rx_s;
            end

            case (state)
                IDLE: begin
                    if (fall) begin
                        n_lat    <= n_next;
                        p_lat    <= cr_p_i;
                        s_lat    <= cr_s_i;
                        div_cnt  <= '0;
                        tick_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (decide) begin
                        if (vote) begin
                            state <= IDLE;
                        end else begin
                            data_sr  <= '0;
                            bit_cnt  <= '0;
                            stop_cnt <= 1'b0;
                            par_q    <= 1'b0;
                            ferr_q   <= 1'b0;
                            zero_q   <= 1'b1;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        data_sr <= {vote, data_sr[DATA_MAX-1:1]};
                        par_q   <= par_q ^ vote;
                        zero_q  <= zero_q & ~vote;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == n_lat - 4'd1) state <= p_lat[1] ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (decide) begin
                        perr_q <= par_q ^ vote ^ p_lat[0];
                        zero_q <= zero_q & ~vote;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (decide) begin
                        ferr_q <= ferr_q | ~vote;
                        zero_q <= zero_q & ~vote;
                        if (stop_cnt == s_lat) begin
                            // Bits were shifted in from the top; right-align for short frames.
                            data_o         <= data_sr >> (4'(DATA_MAX) - n_lat);
                            parity_err_o   <= p_lat[1] & perr_q;
                            frame_err_o    <= ferr_q | ~vote;
                            break_o        <= zero_q & ~vote;
                            output_valid_o <= 1'b1;
                            state          <= vote ? IDLE : WAIT_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frontend_os.sv
// Directed bench for rx_frontend_os: one DATA_MAX=8 instance for most frames and a
// DATA_MAX=9 instance for back-to-back 9-bit frames.
module tb_rx_frontend_os;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div;
    logic [3:0]  ds;
    logic [3:0]  ds2;
    logic [1:0]  p;
    logic        s;
    logic        rx1;
    logic        rx2;
    logic [7:0]  d1;
    logic        pe1, fe1, br1, v1;
    logic [8:0]  d2;
    logic        pe2, fe2, br2, v2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_p = 0;
    int p1 = 0;
    int p2 = 0;
    int last_cyc1 = 0;
    int base;
    logic [8:0] hist2 [4];
    logic [15:0] f;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rx_frontend_os #(.DATA_MAX(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .cr_clk_div_i(div), .cr_ds_i(ds), .cr_p_i(p), .cr_s_i(s),
        .uart_rx_i(rx1), .data_o(d1), .parity_err_o(pe1), .frame_err_o(fe1), .break_o(br1),
        .output_valid_o(v1)
    );

    rx_frontend_os #(.DATA_MAX(9), .OVERSAMPLE(16), .SYNC_STAGES(2)) u_dut9 (
        .clk_i(clk), .rst_i(rst), .cr_clk_div_i(div), .cr_ds_i(ds2), .cr_p_i(p), .cr_s_i(s),
        .uart_rx_i(rx2), .data_o(d2), .parity_err_o(pe2), .frame_err_o(fe2), .break_o(br2),
        .output_valid_o(v2)
    );

    always @(negedge clk) begin
        if (v1) begin
            p1        = p1 + 1;
            last_cyc1 = cyc + 1;
        end
        if (v2) begin
            if (p2 < 4) hist2[p2] = d2;
            p2 = p2 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bit 0 is the start bit; bits past the frame length stay 1 (idle).
    function automatic logic [15:0] mk(input logic [8:0] d, input int n, input int pm,
                                       input int ns, input logic sv);
        logic [15:0] r;
        logic        par;
        int          idx;
        r    = '1;
        r[0] = 1'b0;
        par  = 1'b0;
        for (int i = 0; i < n; i++) begin
            r[1+i] = d[i];
            par    = par ^ d[i];
        end
        idx = 1 + n;
        if (pm >= 2) begin
            r[idx] = par ^ (pm == 3);
            idx++;
        end
        for (int k = 0; k < ns; k++) r[idx+k] = sv;
        return r;
    endfunction

    // Drives one frame; optional one-clock glitch, mid-frame ds change, or reset abort.
    task automatic send(input int sel, input logic [15:0] bits, input int nb, input int bclk,
                        input int gbit, input int goff, input int cbit, input logic [3:0] cds,
                        input int abit);
        logic val;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < bclk; c++) begin
                @(negedge clk);
                if (b == 0 && c == 0) start_p = cyc + 1;
                if (b == abit && c == bclk / 2) begin
                    rst = 1'b1;
                    return;
                end
                if (b == cbit && c == 0) ds = cds;
                val = bits[b] ^ (b == gbit && c == goff);
                if (sel == 1) rx1 = val;
                else          rx2 = val;
            end
        end
    endtask

    initial begin
        rst = 1'b1; div = 16'd0; ds = 4'd7; ds2 = 4'd8; p = 2'b00; s = 1'b0;
        rx1 = 1'b1; rx2 = 1'b1;
        idle(3);
        check("rst_data",  32'(d1),  32'h0);
        check("rst_perr",  32'(pe1), 32'h0);
        check("rst_ferr",  32'(fe1), 32'h0);
        check("rst_break", 32'(br1), 32'h0);
        check("rst_valid", 32'(v1),  32'h0);
        rst = 1'b0;
        idle(5);

        // 8N1 0x5A: exact pulse cycle E+155 with E = pin cycle + 2
        base = p1;
        send(1, mk(9'h05A, 8, 0, 1, 1'b1), 10, 16, -1, 0, -1, 4'd0, -1);
        idle(20);
        check("8n1_pulses", 32'(p1 - base), 32'd1);
        check("8n1_data",   32'(d1),  32'h5A);
        check("8n1_perr",   32'(pe1), 32'h0);
        check("8n1_ferr",   32'(fe1), 32'h0);
        check("8n1_break",  32'(br1), 32'h0);
        check("8n1_cycle",  32'(last_cyc1), 32'(start_p + 2 + 155));

        // 7E2 then 7O2 with the same (even-parity) frame, div=3
        div = 16'd3; ds = 4'd6; p = 2'b10; s = 1'b1;
        f = mk(9'h041, 7, 2, 2, 1'b1);
        base = p1;
        send(1, f, 11, 64, -1, 0, -1, 4'd0, -1);
        idle(80);
        check("7e2_pulses", 32'(p1 - base), 32'd1);
        check("7e2_data",   32'(d1),  32'h41);
        check("7e2_perr",   32'(pe1), 32'h0);
        check("7e2_ferr",   32'(fe1), 32'h0);
        p = 2'b11;
        send(1, f, 11, 64, -1, 0, -1, 4'd0, -1);
        idle(80);
        check("7o2_data",   32'(d1),  32'h41);
        check("7o2_perr",   32'(pe1), 32'h1);

        // Start glitch of 4 clocks, then 0xFF with one corrupted sample in data bit 3
        div = 16'd0; ds = 4'd7; p = 2'b00; s = 1'b0;
        idle(10);
        base = p1;
        @(negedge clk); rx1 = 1'b0;
        idle(4);
        rx1 = 1'b1;
        idle(40);
        check("glitch_nopulse", 32'(p1 - base), 32'd0);
        send(1, mk(9'h0FF, 8, 0, 1, 1'b1), 10, 16, 4, 9, -1, 4'd0, -1);
        idle(20);
        check("bitglitch_pulses", 32'(p1 - base), 32'd1);
        check("bitglitch_data",   32'(d1),  32'hFF);
        check("bitglitch_perr",   32'(pe1), 32'h0);

        // Framing error, held low: one pulse only until the line recovers
        base = p1;
        send(1, mk(9'h033, 8, 0, 1, 1'b0), 10, 16, -1, 0, -1, 4'd0, -1);
        idle(48);
        check("ferr_pulses", 32'(p1 - base), 32'd1);
        check("ferr_data",   32'(d1),  32'h33);
        check("ferr_ferr",   32'(fe1), 32'h1);
        check("ferr_break",  32'(br1), 32'h0);
        rx1 = 1'b1;
        idle(32);

        // Break: 20 bit times low
        base = p1;
        rx1 = 1'b0;
        idle(320);
        check("brk_pulses", 32'(p1 - base), 32'd1);
        check("brk_data",   32'(d1),  32'h0);
        check("brk_ferr",   32'(fe1), 32'h1);
        check("brk_break",  32'(br1), 32'h1);
        rx1 = 1'b1;
        idle(32);

        // ds changes 7 -> 4 during data bit 2; frame still decoded as 8 bits
        send(1, mk(9'h0A5, 8, 0, 1, 1'b1), 10, 16, -1, 0, 3, 4'd4, -1);
        idle(20);
        check("dschg_data", 32'(d1), 32'hA5);
        check("dschg_ferr", 32'(fe1), 32'h0);
        ds = 4'd7;

        // Asynchronous reset during data bit 4
        base = p1;
        send(1, mk(9'h0C3, 8, 0, 1, 1'b1), 10, 16, -1, 0, -1, 4'd0, 5);
        #1;
        check("arst_data",  32'(d1),  32'h0);
        check("arst_valid", 32'(v1),  32'h0);
        check("arst_perr",  32'(pe1), 32'h0);
        check("arst_ferr",  32'(fe1), 32'h0);
        check("arst_break", 32'(br1), 32'h0);
        rx1 = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(200);
        check("arst_nopulse", 32'(p1 - base), 32'd0);
        send(1, mk(9'h03C, 8, 0, 1, 1'b1), 10, 16, -1, 0, -1, 4'd0, -1);
        idle(20);
        check("post_rst_pulses", 32'(p1 - base), 32'd1);
        check("post_rst_data",   32'(d1), 32'h3C);

        // Back-to-back 9N1 frames on the DATA_MAX=9 instance
        base = p2;
        send(2, mk(9'h1FF, 9, 0, 1, 1'b1), 11, 16, -1, 0, -1, 4'd0, -1);
        send(2, mk(9'h001, 9, 0, 1, 1'b1), 11, 16, -1, 0, -1, 4'd0, -1);
        idle(30);
        check("b2b_pulses", 32'(p2 - base), 32'd2);
        check("b2b_first",  32'(hist2[0]), 32'h1FF);
        check("b2b_second", 32'(hist2[1]), 32'h001);
        check("b2b_ferr",   32'(fe2), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_frontend_os.md
# rx_frontend_os

Parametrised oversampling UART receive frontend for the ECAP5-WBUART peripheral. It is the successor of the existing receive frontend: it deserialises the `uart_rx_i` line into a right-aligned data word, using a configurable data width, parity and stop-bit count. It adds input synchronisation, 3-sample majority voting per bit, start-bit glitch rejection, and framing-error and break detection. It sits between the pin and the RX FIFO/register logic, which consumes one pulse-qualified word per frame.

## Interface
Parameters:
- `DATA_MAX`, default 8: maximum data bits per frame; legal range 5..9.
- `OVERSAMPLE`, default 16: ticks per bit; even, minimum 8.
- `SYNC_STAGES`, default 2: flops in the `uart_rx_i` synchroniser; minimum 2.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, asynchronous and active-high.
- `cr_clk_div_i`, in, 16: one oversample tick every `cr_clk_div_i+1` clocks.
- `cr_ds_i`, in, 4: data bits = `cr_ds_i+1`, clamped to the range 5..`DATA_MAX`.
- `cr_p_i`, in, 2: parity mode; 00 and 01 = none, 10 = even, 11 = odd.
- `cr_s_i`, in, 1: stop bits; 0 = one, 1 = two.
- `uart_rx_i`, in, 1: asynchronous serial line; idle level is high.
- `data_o`, out, `DATA_MAX`: received word, LSB-first on the line, right-aligned, upper bits zero.
- `parity_err_o`, out, 1: parity mismatch for the current word.
- `frame_err_o`, out, 1: a stop bit was voted 0.
- `break_o`, out, 1: every voted bit of the frame after the start bit was 0.
- `output_valid_o`, out, 1: one-cycle pulse qualifying all outputs above.

## Operation
- **Synchroniser.** `SYNC_STAGES` flops, all reset to 1. Falling-edge detection compares the last stage with a registered copy.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- **IDLE.** On a falling edge:
  - latch `cr_ds_i`, `cr_p_i` and `cr_s_i` for the whole frame; mid-frame changes are ignored;
  - clear the divider and the tick counter (0..`OVERSAMPLE`-1);
  - go to START.
- **Majority vote.** Each bit is sampled at tick counts `OVERSAMPLE/2-1`, `OVERSAMPLE/2` and `OVERSAMPLE/2+1`. The voted value is the majority of the three and is decided on the last of those samples.
- **START.**
  - Vote 1: treat as a glitch and return to IDLE; no output pulse.
  - Vote 0: go to DATA.
- **DATA.** Shift the voted bits in LSB-first. After the last data bit, go to PARITY if parity is enabled, else STOP.
- **PARITY.**
  - Even mode: `parity_err_o` = XOR(data bits, parity bit).
  - Odd mode: `parity_err_o` is the inverse of that.
  - With no parity, `parity_err_o` = 0.
- **STOP.** Vote one or two stop bits. `frame_err_o` = 1 if any voted stop bit is 0. When the last stop bit is decided:
  - register all outputs and pulse `output_valid_o`;
  - go to IDLE if that last stop bit voted 1, else go to WAIT_IDLE.
- **Break.** `break_o` = 1 when all data bits, the parity bit (if enabled) and all stop bits voted 0. Break implies `frame_err_o` = 1.
- **WAIT_IDLE.** Stay until the synchronised line is 1, then go to IDLE. A falling edge seen in WAIT_IDLE is not a start bit.
- **Output holding.** `data_o` and the error flags hold their values until the next valid frame. They change only in the cycle `output_valid_o` rises.
- **Reset.** Asynchronous reset at any point, including mid-frame, forces IDLE. It drives `data_o`=0, `parity_err_o`=0, `frame_err_o`=0, `break_o`=0 and `output_valid_o`=0. No partial frame is reported.
- **No-tick boundary.** If no tick arrives (impossible: the divider minimum is 1 clock), the FSM holds state.

## Timing
- Define E as the cycle the falling edge is detected, which is `SYNC_STAGES` cycles after the pin edge.
- Tick k occurs in cycle E + k·(`cr_clk_div_i`+1), for k ≥ 1.
- The vote of bit index b is decided at tick b·`OVERSAMPLE` + `OVERSAMPLE/2` + 2. Index 0 is the start bit.
- Let L = N + P + S, where N = data bits, P = 0 or 1, S = 1 or 2. `output_valid_o` is high in cycle E + (L·`OVERSAMPLE` + `OVERSAMPLE/2` + 2)·(`cr_clk_div_i`+1) + 1.
- Throughput: the next frame may start with the falling edge immediately after the stop-bit decision. Back-to-back frames are not lost.

## Test plan
- **8N1, frame 0x5A.** `DATA_MAX`=8, `OVERSAMPLE`=16, div=0, ds=7, p=00, s=0; send 0x5A at 16 clocks/bit → `data_o`=0x5A, no error flags, `output_valid_o` pulse exactly at E+155.
- **7E2 and 7O2.** ds=6, p=10, s=1, div=3; send 0x41 with correct even parity → `data_o`=0x41, `parity_err_o`=0. Repeat with p=11 → `parity_err_o`=1.
- **Start glitch and bit glitch.** Drive the line low for 4 bit-clocks (< `OVERSAMPLE/2`-1 ticks) → no pulse, FSM back in IDLE. Then corrupt one of the three mid-bit samples of data bit 3 in frame 0xFF → `data_o`=0xFF.
- **Framing error and break.** 8N1 frame 0x33 with stop bit 0 → `frame_err_o`=1, `break_o`=0, no new frame until the line goes high. Hold the line low for 20 bit times → one pulse with `data_o`=0, `frame_err_o`=1, `break_o`=1.
- **Mid-frame changes and reset.** Change ds from 7 to 4 during data bit 2 of 8N1 frame 0xA5 → `data_o`=0xA5. Assert `rst_i` asynchronously in data bit 4 → all outputs 0 immediately, no pulse. The next clean frame 0x3C → `data_o`=0x3C.
- **Back-to-back.** `DATA_MAX`=9, ds=8, 9-bit frames 0x1FF then 0x001 with no idle gap → two pulses, `data_o`=0x1FF then 0x001.
